uart_txrx: RTL and testbench
============================

UART_TXRX -- requirements
Module: uart_txrx

Interface
REQ-001 Parameter CLK_HZ, default 210000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter OSR_DIV, default 114 (= CLK_HZ/(16*BAUD), rounded), clocks per 16x tick.
REQ-004 clk210_p  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_p  in  1  synchronous, active-high reset.
REQ-006 baud_16_x_p  out  1  one-clock pulse every OSR_DIV clocks.
REQ-007 baud_1_x_p  out  1  one-clock pulse on every 16th baud_16_x_p pulse.
REQ-008 tx_p  out  1  serial transmit line; idle high.
REQ-009 transmit_data_p  in  8  byte to send.
REQ-010 transmit_req_p  in  1  transmit request (rising-edge sensitive).
REQ-011 transmit_done_p  out  1  frame sent; held until acknowledged.
REQ-012 transmit_done_ack_p  in  1  clears transmit_done_p.
REQ-013 rx_p  in  1  serial receive line; idle high.
REQ-014 received_data_p  out  8  last correctly received byte.
REQ-015 received_data_read_req_p  out  1  new byte available; held until acknowledged.
REQ-016 received_data_ack_p  in  1  clears received_data_read_req_p.

Function
REQ-017 Baud divider SHALL count 0..OSR_DIV-1 and pulse baud_16_x_p when the count wraps; a 4-bit tick counter SHALL pulse baud_1_x_p coincident with every 16th baud_16_x_p.
REQ-018 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; one bit lasts one baud_1_x_p period (16*OSR_DIV = 1824 clocks at defaults).
REQ-019 TX states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-020 In IDLE with transmit_done_p low, a 0->1 transition of transmit_req_p SHALL latch transmit_data_p and move to START.
REQ-021 START, each DATA bit and STOP SHALL each begin and end on baud_1_x_p pulses; tx_p changes only on those pulses.
REQ-022 After the STOP bit, TX SHALL enter DONE, set transmit_done_p and keep tx_p high.
REQ-023 transmit_done_ack_p high in DONE SHALL clear transmit_done_p on the next clock and return TX to IDLE; a request held high SHALL NOT retrigger without a new rising edge.
REQ-024 Request edges during START/DATA/STOP/DONE SHALL be ignored; the latched byte SHALL not change mid-frame.
REQ-025 RX states SHALL be IDLE, START, DATA, STOP.
REQ-026 RX SHALL count baud_16_x_p ticks; in IDLE a low rx_p starts START; rx_p still low at tick 8 confirms the start bit, otherwise RX returns to IDLE (glitch rejection).
REQ-027 Data bits SHALL be sampled every 16 ticks after the start-bit midpoint, shifted in LSB first.
REQ-028 If the stop-bit sample is 1, received_data_p SHALL update and received_data_read_req_p SHALL be set; if 0 (framing error), the byte SHALL be discarded and outputs unchanged.
REQ-029 received_data_ack_p high SHALL clear received_data_read_req_p on the next clock.
REQ-030 If a new valid byte completes while received_data_read_req_p is high, received_data_p SHALL be overwritten and the request stays high; if it completes in the same clock as an ack, the request SHALL remain set.
REQ-031 RX SHALL be ready for a new start bit right after the stop-bit sample.

Reset
REQ-032 While reset_p is high: divider and tick counters 0, baud_16_x_p=0, baud_1_x_p=0, tx_p=1, transmit_done_p=0, received_data_p=8'h00, received_data_read_req_p=0, both state machines IDLE, request-edge history 0.
REQ-033 Reset asserted mid-frame SHALL abort both frames immediately; tx_p SHALL be 1 on the clock after reset.

Configuration
REQ-034 Macro UART_RX_SYNC_EN defined: rx_p SHALL pass through a two-flop synchronizer (reset value 1) before RX logic, adding 2 clocks of latency.
REQ-035 Macro UART_RX_SYNC_EN undefined: RX logic SHALL sample rx_p directly.

Verification
REQ-036 After reset release, baud_16_x_p pulses every 114 clocks; baud_1_x_p pulses every 1824 clocks, aligned with a 16x pulse.
REQ-037 Loopback (rx_p=tx_p), transmit_data_p=8'hD5, rising transmit_req_p -> tx_p sequence 0,1,0,1,0,1,0,1,1,1 per bit period; transmit_done_p rises after the stop bit; received_data_p=8'hD5 and received_data_read_req_p=1.
REQ-038 Pulse transmit_done_ack_p for 1 clock -> transmit_done_p low next clock; keep transmit_req_p high -> no second frame (tx_p stays 1).
REQ-039 Pulse received_data_ack_p -> received_data_read_req_p low next clock; received_data_p holds 8'hD5.
REQ-040 Drive rx_p low for 4 ticks only -> no request; drive a frame with stop bit 0 -> no request, received_data_p unchanged.
REQ-041 Assert reset_p during DATA bit 3 -> tx_p=1, transmit_done_p=0, both machines IDLE; a subsequent 8'h3C transfer completes correctly.

Source files
------------

// File: rtl/uart_txrx.sv
// 8N1 UART transmitter/receiver with a shared 16x oversampling baud generator.
// Optional UART_RX_SYNC_EN adds a two-flop synchronizer on rx_p.
module uart_txrx #(
  parameter int CLK_HZ  = 210000000,
  parameter int BAUD    = 115200,
  parameter int OSR_DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD)
) (
  input  logic       clk210_p,
  input  logic       reset_p,
  output logic       baud_16_x_p,
  output logic       baud_1_x_p,
  output logic       tx_p,
  input  logic [7:0] transmit_data_p,
  input  logic       transmit_req_p,
  output logic       transmit_done_p,
  input  logic       transmit_done_ack_p,
  input  logic       rx_p,
  output logic [7:0] received_data_p,
  output logic       received_data_read_req_p,
  input  logic       received_data_ack_p
);

  localparam int DW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  logic [DW-1:0] div_cnt;
  logic [3:0]    tick_cnt;
  logic          tick16;
  logic          tick1;

  assign tick16 = (div_cnt == DW'(OSR_DIV - 1));
  assign tick1  = tick16 && (tick_cnt == 4'd15);

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      div_cnt     <= '0;
      tick_cnt    <= '0;
      baud_16_x_p <= 1'b0;
      baud_1_x_p  <= 1'b0;
    end else begin
      baud_16_x_p <= tick16;
      baud_1_x_p  <= tick1;
      if (tick16) begin
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'd1;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  logic rx_s;
`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;
  always_ff @(posedge clk210_p) begin
    if (reset_p) rx_sync <= 2'b11;
    else         rx_sync <= {rx_sync[0], rx_p};
  end
  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx_p;
`endif

  tx_state_t tx_state, tx_state_n;
  logic [7:0] tx_byte, tx_byte_n;
  logic [2:0] tx_idx, tx_idx_n;
  logic       tx_armed, tx_armed_n;
  logic       tx_n, done_n, req_q;

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      tx_state        <= TX_IDLE;
      tx_byte         <= '0;
      tx_idx          <= '0;
      tx_armed        <= 1'b0;
      tx_p            <= 1'b1;
      transmit_done_p <= 1'b0;
      req_q           <= 1'b0;
    end else begin
      tx_state        <= tx_state_n;
      tx_byte         <= tx_byte_n;
      tx_idx          <= tx_idx_n;
      tx_armed        <= tx_armed_n;
      tx_p            <= tx_n;
      transmit_done_p <= done_n;
      req_q           <= transmit_req_p;
    end
  end

  // START waits one baud period before dropping the line so every bit
  // boundary lands on a baud_1_x_p pulse.
  always_comb begin
    tx_state_n = tx_state;
    tx_byte_n  = tx_byte;
    tx_idx_n   = tx_idx;
    tx_armed_n = tx_armed;
    tx_n       = tx_p;
    done_n     = transmit_done_p;
    unique case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (!transmit_done_p && transmit_req_p && !req_q) begin
          tx_state_n = TX_START;
          tx_byte_n  = transmit_data_p;
          tx_armed_n = 1'b0;
        end
      end
      TX_START: begin
        if (tick1) begin
          if (!tx_armed) begin
            tx_n       = 1'b0;
            tx_armed_n = 1'b1;
          end else begin
            tx_n       = tx_byte[0];
            tx_idx_n   = 3'd0;
            tx_state_n = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (tick1) begin
          if (tx_idx == 3'd7) begin
            tx_n       = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
            tx_n     = tx_byte[tx_idx + 3'd1];
          end
        end
      end
      TX_STOP: begin
        if (tick1) begin
          tx_state_n = TX_DONE;
          done_n     = 1'b1;
        end
      end
      TX_DONE: begin
        tx_n = 1'b1;
        if (transmit_done_ack_p) begin
          done_n     = 1'b0;
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  rx_state_t rx_state, rx_state_n;
  logic [3:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n, rdata_n;
  logic       rreq_n;

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      rx_state                 <= RX_IDLE;
      rx_cnt                   <= '0;
      rx_bit                   <= '0;
      rx_sh                    <= '0;
      received_data_p          <= 8'h00;
      received_data_read_req_p <= 1'b0;
    end else begin
      rx_state                 <= rx_state_n;
      rx_cnt                   <= rx_cnt_n;
      rx_bit                   <= rx_bit_n;
      rx_sh                    <= rx_sh_n;
      received_data_p          <= rdata_n;
      received_data_read_req_p <= rreq_n;
    end
  end

  // A completing byte sets the request after the ack clears it, so set wins.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rdata_n    = received_data_p;
    rreq_n     = received_data_read_req_p;
    if (received_data_ack_p) rreq_n = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = 4'd0;
        end
      end
      RX_START: begin
        if (tick16) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == 4'd7) begin
            rx_cnt_n   = 4'd0;
            rx_bit_n   = 3'd0;
            rx_state_n = rx_s ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick16) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_sh_n  = {rx_s, rx_sh[7:1]};
            rx_bit_n = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick16) begin
          rx_cnt_n = rx_cnt + 4'd1;
          if (rx_cnt == 4'd15) begin
            rx_state_n = RX_IDLE;
            if (rx_s) begin
              rdata_n = rx_sh;
              rreq_n  = 1'b1;
            end
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: baud timing, loopback frames, acks,
// glitch and framing-error rejection, mid-frame reset.
module tb_uart_txrx;

  logic       clk = 1'b0;
  logic       rst;
  logic       b16, b1, tx, rx;
  logic [7:0] tdata;
  logic       treq, tdone, tack;
  logic [7:0] rdata;
  logic       rreq, rack;
  logic       loop_en, rx_drv;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_txrx dut (
    .clk210_p                 (clk),
    .reset_p                  (rst),
    .baud_16_x_p              (b16),
    .baud_1_x_p               (b1),
    .tx_p                     (tx),
    .transmit_data_p          (tdata),
    .transmit_req_p           (treq),
    .transmit_done_p          (tdone),
    .transmit_done_ack_p      (tack),
    .rx_p                     (rx),
    .received_data_p          (rdata),
    .received_data_read_req_p (rreq),
    .received_data_ack_p      (rack)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic timeout(input string tag);
    ntests++;
    nfail++;
    $error("FAIL %s: got timeout expected pulse", tag);
  endtask

  task automatic wait_b1(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (b1) return;
    end
    timeout("b1_wait");
  endtask

  task automatic wait_b16(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (b16) return;
    end
    timeout("b16_wait");
  endtask

  task automatic loop_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      wait_b1(2000);
      check($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, f[i]});
    end
    check("done_before_stop_end", {31'd0, tdone}, 32'd0);
    wait_b1(2000);
    check("done_set", {31'd0, tdone}, 32'd1);
    check("tx_idle_done", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    int n;
    logic any_low;
    logic [7:0] fb;
    rst = 1'b1; tdata = 8'h00; treq = 1'b0; tack = 1'b0;
    rack = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
    tick(3);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_done", {31'd0, tdone}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'h00);
    check("rst_rreq", {31'd0, rreq}, 32'd0);
    check("rst_b16", {31'd0, b16}, 32'd0);
    check("rst_b1", {31'd0, b1}, 32'd0);
    rst = 1'b0;

    wait_b16(300);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (b16) break;
    end
    check("b16_period", n, 114);
    wait_b1(2000);
    check("b1_aligned_b16", {31'd0, b16}, 32'd1);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      n++;
      if (b1) break;
    end
    check("b1_period", n, 1824);

    loop_en = 1'b1;
    tdata = 8'hD5;
    treq = 1'b1;
    tick(1);
    tdata = 8'h00;
    loop_frame(8'hD5);
    check("rx_rdata_d5", {24'd0, rdata}, 32'hD5);
    check("rx_rreq_d5", {31'd0, rreq}, 32'd1);

    tack = 1'b1;
    tick(1);
    tack = 1'b0;
    check("done_cleared", {31'd0, tdone}, 32'd0);
    any_low = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!tx) any_low = 1'b1;
    end
    check("no_retrigger", {31'd0, any_low}, 32'd0);
    check("done_stays_low", {31'd0, tdone}, 32'd0);

    rack = 1'b1;
    tick(1);
    rack = 1'b0;
    check("rreq_cleared", {31'd0, rreq}, 32'd0);
    check("rdata_hold", {24'd0, rdata}, 32'hD5);

    loop_en = 1'b0;
    rx_drv = 1'b0;
    tick(4 * 114);
    rx_drv = 1'b1;
    tick(20 * 114);
    check("glitch_rreq", {31'd0, rreq}, 32'd0);
    check("glitch_rdata", {24'd0, rdata}, 32'hD5);

    fb = 8'hA7;
    rx_drv = 1'b0;
    tick(1824);
    for (int i = 0; i < 8; i++) begin
      rx_drv = fb[i];
      tick(1824);
    end
    rx_drv = 1'b0;
    tick(1824);
    rx_drv = 1'b1;
    tick(3000);
    check("frame_err_rreq", {31'd0, rreq}, 32'd0);
    check("frame_err_rdata", {24'd0, rdata}, 32'hD5);

    treq = 1'b0;
    tick(2);
    loop_en = 1'b1;
    tdata = 8'h3C;
    treq = 1'b1;
    for (int i = 0; i < 5; i++) wait_b1(2000);
    check("tx_bit3_3c", {31'd0, tx}, 32'd1);
    tick(900);
    rst = 1'b1;
    treq = 1'b0;
    tick(1);
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_done", {31'd0, tdone}, 32'd0);
    check("mid_rst_rdata", {24'd0, rdata}, 32'h00);
    tick(1);
    rst = 1'b0;
    tick(300);
    check("post_rst_tx_idle", {31'd0, tx}, 32'd1);
    check("post_rst_rreq", {31'd0, rreq}, 32'd0);

    treq = 1'b1;
    tick(1);
    loop_frame(8'h3C);
    check("rx_rdata_3c", {24'd0, rdata}, 32'h3C);
    check("rx_rreq_3c", {31'd0, rreq}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
